// File: rtl/train_pkg.sv
// Shared types and constants for the training-loop sequencer.
package train_pkg;
  localparam int CNTW     = 16;
  localparam int ACCW_DEF = 48;
  localparam logic [ACCW_DEF-1:0] ACC_MAX = '1;

  typedef enum logic [3:0] {
    IDLE, INIT, TR_ISSUE, TR_STEP, TR_WAIT, VL_ISSUE, VL_STEP, VL_WAIT, EVAL, STORE, FIN
  } state_t;

  // Where an epoch begins: training if any, else validation, else straight to evaluation.
  function automatic state_t phase_entry(input logic tr_nz, input logic vl_nz);
    if (tr_nz) return TR_ISSUE;
    if (vl_nz) return VL_ISSUE;
    return EVAL;
  endfunction
endpackage

// File: rtl/train_sequencer_if.sv
// Control, Pattern and Architecture signals of the sequencer, bundled.
interface train_sequencer_if #(
  parameter int BITS = 32,
  parameter int ACCW = BITS + 16
);
  import train_pkg::*;

  logic            go, halt;
  logic [BITS-1:0] TRAIN, VALID, EPOCH;
  logic            step_done;
  logic [BITS-1:0] err;
  logic            START, END, TR, VL, SW, step;
  logic [CNTW-1:0] epoch, sample;
  logic [ACCW-1:0] best_err;
  logic [CNTW-1:0] best_epoch;
  logic            busy;

  modport master (
    input  go, halt, TRAIN, VALID, EPOCH, step_done, err,
    output START, END, TR, VL, SW, step, epoch, sample, best_err, best_epoch, busy
  );
  modport slave (
    output go, halt, TRAIN, VALID, EPOCH, step_done, err,
    input  START, END, TR, VL, SW, step, epoch, sample, best_err, best_epoch, busy
  );
endinterface

// File: rtl/sat_acc.sv
// Saturating accumulator for per-epoch validation error.
module sat_acc #(
  parameter int BITS = 32,
  parameter int ACCW = BITS + 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            add_en,
  input  logic [BITS-1:0] din,
  output logic [ACCW-1:0] acc
);
  logic [ACCW:0] sum;

  assign sum = {1'b0, acc} + {{(ACCW + 1 - BITS){1'b0}}, din};

  // Clear wins over add; a carry out of the top bit pins the value at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (add_en) acc <= sum[ACCW] ? '1 : sum[ACCW-1:0];
  end
endmodule

// File: rtl/train_sequencer.sv
// Epoch/sample scheduler: drives Pattern strobes, hands samples to the
// Architecture and keeps the best validation epoch.
module train_sequencer #(
  parameter int BITS = 32,
  parameter int ACCW = BITS + 16
) (
  input logic               clk,
  input logic               rst,
  train_sequencer_if.master bus
);
  import train_pkg::*;

  state_t          state, nxt;
  logic [CNTW-1:0] n_tr, n_vl, n_ep;
  logic [ACCW-1:0] acc;
  logic            tr_nz, vl_nz, last_tr, last_vl, last_ep, better, abort, start;
  logic            acc_clr, acc_add;
  logic            unused_hi;

  // Only the low counter bits of the published counts matter.
  assign unused_hi = ^{bus.TRAIN[BITS-1:CNTW], bus.VALID[BITS-1:CNTW], bus.EPOCH[BITS-1:CNTW]};

  assign tr_nz   = n_tr != '0;
  assign vl_nz   = n_vl != '0;
  assign last_tr = ({1'b0, bus.sample} + (CNTW+1)'(1)) >= {1'b0, n_tr};
  assign last_vl = ({1'b0, bus.sample} + (CNTW+1)'(1)) >= {1'b0, n_vl};
  assign last_ep = ({1'b0, bus.epoch}  + (CNTW+1)'(1)) == {1'b0, n_ep};
  assign better  = vl_nz && (acc < bus.best_err);
  assign abort   = bus.halt && state != IDLE && state != FIN;
  assign start   = state == IDLE && bus.go;
  assign acc_clr = start || state == STORE || (state == EVAL && !better);
  assign acc_add = state == VL_WAIT && bus.step_done && !abort;

  sat_acc #(.BITS(BITS), .ACCW(ACCW)) u_acc (
    .clk(clk), .rst(rst), .clr(acc_clr), .add_en(acc_add), .din(bus.err), .acc(acc)
  );

  // Next-state decode; halt overrides every other transition.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (bus.go) nxt = INIT;
      INIT:     nxt = (n_ep == '0) ? FIN : phase_entry(tr_nz, vl_nz);
      TR_ISSUE: nxt = TR_STEP;
      TR_STEP:  nxt = TR_WAIT;
      TR_WAIT:  if (bus.step_done) nxt = last_tr ? phase_entry(1'b0, vl_nz) : TR_ISSUE;
      VL_ISSUE: nxt = VL_STEP;
      VL_STEP:  nxt = VL_WAIT;
      VL_WAIT:  if (bus.step_done) nxt = last_vl ? EVAL : VL_ISSUE;
      EVAL:     nxt = better ? STORE : (last_ep ? FIN : phase_entry(tr_nz, vl_nz));
      STORE:    nxt = last_ep ? FIN : phase_entry(tr_nz, vl_nz);
      FIN:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = FIN;
  end

  // State, counters and best-epoch tracking; strobes are decoded from the next state so each is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      bus.START      <= 1'b0;
      bus.TR         <= 1'b0;
      bus.VL         <= 1'b0;
      bus.SW         <= 1'b0;
      bus.END        <= 1'b0;
      bus.step       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.epoch      <= '0;
      bus.sample     <= '0;
      bus.best_err   <= '1;
      bus.best_epoch <= '0;
      n_tr           <= '0;
      n_vl           <= '0;
      n_ep           <= '0;
    end else begin
      state     <= nxt;
      bus.START <= nxt == INIT;
      bus.TR    <= nxt == TR_ISSUE;
      bus.VL    <= nxt == VL_ISSUE;
      bus.SW    <= nxt == STORE;
      bus.END   <= nxt == FIN;
      bus.step  <= nxt == TR_STEP || nxt == VL_STEP;
      bus.busy  <= nxt != IDLE;
      if (start) begin
        n_tr           <= bus.TRAIN[CNTW-1:0];
        n_vl           <= bus.VALID[CNTW-1:0];
        n_ep           <= bus.EPOCH[CNTW-1:0];
        bus.epoch      <= '0;
        bus.sample     <= '0;
        bus.best_err   <= '1;
        bus.best_epoch <= '0;
      end else if (!abort) begin
        case (state)
          TR_WAIT: if (bus.step_done) bus.sample <= last_tr ? '0 : bus.sample + CNTW'(1);
          VL_WAIT: if (bus.step_done) bus.sample <= last_vl ? '0 : bus.sample + CNTW'(1);
          EVAL: begin
            if (better) begin
              bus.best_err   <= acc;
              bus.best_epoch <= bus.epoch;
            end else begin
              bus.epoch <= bus.epoch + CNTW'(1);
            end
          end
          STORE:   bus.epoch <= bus.epoch + CNTW'(1);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: an event-trace model of the training loop is
// checked against the DUT strobes every cycle, plus literal expectations.
module tb_train_sequencer;
  localparam int BITS  = 32;
  localparam int ACCW  = BITS + 16;
  localparam int ACCW2 = BITS + 2;
  localparam logic [ACCW-1:0] ALL1 = '1;
  localparam int K_START = 0, K_TR = 1, K_VL = 2, K_STEP = 3, K_SW = 4, K_END = 5;

  typedef struct { int k; int e; int s; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  train_sequencer_if #(.BITS(BITS), .ACCW(ACCW))  bus();
  train_sequencer_if #(.BITS(BITS), .ACCW(ACCW2)) bus2();

  train_sequencer #(.BITS(BITS), .ACCW(ACCW))  dut  (.clk(clk), .rst(rst), .bus(bus));
  train_sequencer #(.BITS(BITS), .ACCW(ACCW2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad = 0;
  ev_t q[$];
  logic [31:0] errs[$];
  logic [31:0] errq[$];
  logic [63:0] m_best;
  int m_bep;
  int n_cnt[6];
  int dly = 2;
  bit echo = 0;
  bit poke = 0;
  bit vl_phase = 0;
  int pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected strobe trace of a whole run, straight from the epoch/sample rules.
  task automatic build(input int tr, input int vl, input int ep, input int halt_ep);
    logic [63:0] sum;
    int idx;
    idx = 0;
    q.delete();
    m_best = ALL1;
    m_bep = 0;
    q.push_back(ev_t'{K_START, 0, 0});
    for (int e = 0; e < ep; e++) begin
      for (int s = 0; s < tr; s++) begin
        q.push_back(ev_t'{K_TR, e, s});
        q.push_back(ev_t'{K_STEP, e, s});
        if (e == halt_ep) begin
          q.push_back(ev_t'{K_END, e, s});
          return;
        end
      end
      sum = 0;
      for (int s = 0; s < vl; s++) begin
        q.push_back(ev_t'{K_VL, e, s});
        q.push_back(ev_t'{K_STEP, e, s});
        sum = sum + errs[idx];
        idx++;
        if (sum > ALL1) sum = ALL1;
      end
      if (vl != 0 && sum < m_best) begin
        m_best = sum;
        m_bep = e;
        q.push_back(ev_t'{K_SW, e, 0});
      end
    end
    q.push_back(ev_t'{K_END, ep, 0});
  endtask

  // Architecture stand-in: step_done dly cycles after each step, err from errq in validation.
  initial begin
    bus.step_done = 1'b0;
    bus.err = '0;
    forever begin
      @(posedge clk); #1;
      bus.step_done = 1'b0;
      if (bus.TR) vl_phase = 0;
      if (bus.VL) vl_phase = 1;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.step_done = 1'b1;
          if (vl_phase && errq.size() > 0) bus.err = errq.pop_front();
          else bus.err = 32'h0FFF_FFFF;
        end
      end
      if (bus.step) begin
        pend = dly;
        if (echo) begin
          bus.step_done = 1'b1;
          bus.err = 32'h0FFF_FFFF;
        end
      end
      if (poke) begin
        bus.step_done = 1'b1;
        bus.err = 32'h0FFF_FFFF;
      end
    end
  end

  // Every cycle: at most one strobe, and each strobe must be the next model event.
  initial forever begin
    @(negedge clk);
    begin
      int n, k;
      ev_t x;
      n = int'(bus.START) + int'(bus.TR) + int'(bus.VL) + int'(bus.SW) + int'(bus.END) + int'(bus.step);
      total++;
      if (n > 1) begin
        bad++;
        $display("FAIL onehot: %0d strobes high, want at most 1", n);
      end
      if (n == 1) begin
        k = bus.START ? K_START : bus.TR ? K_TR : bus.VL ? K_VL : bus.step ? K_STEP : bus.SW ? K_SW : K_END;
        n_cnt[k]++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL event: got kind=%0d ep=%0d smp=%0d, want no event", k, bus.epoch, bus.sample);
        end else begin
          x = q.pop_front();
          if (x.k != k || x.e != int'(bus.epoch) || x.s != int'(bus.sample)) begin
            bad++;
            $display("FAIL event: got kind=%0d ep=%0d smp=%0d, want kind=%0d ep=%0d smp=%0d",
                     k, bus.epoch, bus.sample, x.k, x.e, x.s);
          end
        end
      end
    end
  end

  task automatic run(input int tr, input int vl, input int ep, input int d, input int halt_ep, input bit stray_go);
    bit seen;
    int hcyc;
    seen = 0;
    hcyc = -1;
    errq = errs;
    dly = d;
    build(tr, vl, ep, halt_ep);
    foreach (n_cnt[i]) n_cnt[i] = 0;
    @(posedge clk); #1;
    bus.TRAIN = 32'hABCD_0000 | tr;
    bus.VALID = 32'h1234_0000 | vl;
    bus.EPOCH = 32'h5A5A_0000 | ep;
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    bus.TRAIN = 32'd9; bus.VALID = 32'd9; bus.EPOCH = 32'd9;
    for (int i = 0; i < 4000; i++) begin
      bus.go = (stray_go && i == 8);
      if (hcyc >= 0 && i == hcyc + 1) bus.halt = 1'b1;
      if (hcyc >= 0 && i == hcyc + 2) begin
        bus.halt = 1'b0;
        chk("halt_end_next", bus.END, 1);
      end
      if (bus.END) begin
        seen = 1;
        break;
      end
      if (halt_ep >= 0 && hcyc < 0 && bus.step && int'(bus.epoch) == halt_ep && !vl_phase) hcyc = i;
      @(posedge clk); #1;
    end
    bus.go = 1'b0;
    chk("end_seen", seen, 1);
    @(posedge clk); #1;
    chk("busy_after_end", bus.busy, 0);
    chk("events_left", q.size(), 0);
    chk("best_err", bus.best_err, m_best);
    chk("best_epoch", bus.best_epoch, m_bep);
  endtask

  // Saturation run on the narrow-accumulator instance, every err all-ones.
  task automatic sat_run(input int vl, output int sw_cnt, output bit seen);
    bit pstep;
    sw_cnt = 0;
    seen = 0;
    pstep = 0;
    @(posedge clk); #1;
    bus2.TRAIN = 0; bus2.VALID = vl; bus2.EPOCH = 1; bus2.go = 1'b1;
    @(posedge clk); #1;
    bus2.go = 1'b0;
    for (int i = 0; i < 200; i++) begin
      bus2.step_done = pstep;
      pstep = bus2.step;
      if (bus2.SW) sw_cnt++;
      if (bus2.END) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus2.step_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw;
    bit seen;
    bus.go = 0; bus.halt = 0; bus.TRAIN = 0; bus.VALID = 0; bus.EPOCH = 0;
    bus2.go = 0; bus2.halt = 0; bus2.TRAIN = 0; bus2.VALID = 0; bus2.EPOCH = 0;
    bus2.step_done = 0; bus2.err = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.START, bus.TR, bus.VL, bus.SW, bus.END, bus.step}, 0);
    chk("rst_cnt", {bus.epoch, bus.sample}, 0);
    chk("rst_best_err", bus.best_err, train_pkg::ACC_MAX);
    chk("rst_best_epoch", bus.best_epoch, 0);
    rst = 1'b0;

    // nominal: sums 5 then 2
    errs = '{32'd3, 32'd2, 32'd1, 32'd1};
    run(3, 2, 2, 2, -1, 0);
    chk("nom_start", n_cnt[K_START], 1);
    chk("nom_tr", n_cnt[K_TR], 6);
    chk("nom_vl", n_cnt[K_VL], 4);
    chk("nom_end", n_cnt[K_END], 1);
    chk("nom_epoch", bus.epoch, 2);
    chk("nom_best_lit", bus.best_err, 2);

    // best tracking 10,7,9,7 with stray go and same-cycle step_done
    errs = '{32'd4, 32'd6, 32'd3, 32'd4, 32'd5, 32'd4, 32'd2, 32'd5};
    echo = 1;
    run(1, 2, 4, 1, -1, 1);
    echo = 0;
    chk("best_sw", n_cnt[K_SW], 2);
    chk("best_err_lit", bus.best_err, 7);
    chk("best_epoch_lit", bus.best_epoch, 1);
    chk("best_start", n_cnt[K_START], 1);

    // EPOCH=0
    errs = {};
    build(4, 4, 0, -1);
    @(posedge clk); #1;
    bus.TRAIN = 4; bus.VALID = 4; bus.EPOCH = 0; bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    chk("ep0_start", bus.START, 1);
    @(posedge clk); #1;
    chk("ep0_end", bus.END, 1);
    @(posedge clk); #1;
    chk("ep0_idle", bus.busy, 0);
    chk("ep0_events_left", q.size(), 0);

    // VALID=0
    errs = {};
    run(2, 0, 3, 2, -1, 0);
    chk("v0_tr", n_cnt[K_TR], 6);
    chk("v0_vl", n_cnt[K_VL], 0);
    chk("v0_sw", n_cnt[K_SW], 0);
    chk("v0_best", bus.best_err, train_pkg::ACC_MAX);
    chk("v0_epoch", bus.epoch, 3);

    // halt in TR_WAIT of epoch 1
    errs = '{32'd3, 32'd2, 32'd1, 32'd1};
    run(3, 2, 2, 3, 1, 0);
    chk("halt_tr", n_cnt[K_TR], 4);
    chk("halt_best_lit", bus.best_err, 5);
    chk("halt_bep_lit", bus.best_epoch, 0);

    // restart after abort: equal sums, strict compare keeps epoch 0
    errs = '{32'd1, 32'd1, 32'd1, 32'd1};
    run(3, 2, 2, 2, -1, 0);
    chk("restart_sw", n_cnt[K_SW], 1);
    chk("restart_bep", bus.best_epoch, 0);

    // async reset mid-validation
    errs = '{32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
    errq = errs;
    dly = 2;
    build(1, 3, 2, -1);
    @(posedge clk); #1;
    bus.TRAIN = 1; bus.VALID = 3; bus.EPOCH = 2; bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.VL) break;
      @(posedge clk); #1;
    end
    chk("rst_vl_seen", bus.VL, 1);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    chk("arst_strobes", {bus.START, bus.TR, bus.VL, bus.SW, bus.END, bus.step, bus.busy}, 0);
    chk("arst_cnt", {bus.epoch, bus.sample}, 0);
    chk("arst_best", bus.best_err, ALL1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    // stray step_done while idle
    poke = 1;
    repeat (3) @(posedge clk);
    #1;
    poke = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_cnt", {bus.epoch, bus.sample}, 0);

    // saturation on a 34-bit accumulator
    sat_run(4, sw, seen);
    chk("sat4_end", seen, 1);
    chk("sat4_sw", sw, 1);
    chk("sat4_best", bus2.best_err, 64'h3_FFFF_FFFC);
    sat_run(5, sw, seen);
    chk("sat5_end", seen, 1);
    chk("sat5_sw", sw, 0);
    chk("sat5_best", bus2.best_err, 64'h3_FFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/train_sequencer.md
# train_sequencer

Epoch/sample scheduler for the neural-network training loop. It reads the sample and epoch counts published by the Pattern block and drives Pattern's TR/VL/SW/START/END strobes. It hands each presented sample to the Architecture with a step/step_done handshake, and accumulates validation error per epoch. It issues SW only when an epoch's validation error beats the best seen so far, so Pattern always holds the best weights.

## Interface
- BITS, 32, data/count width (matches Pattern)
- ACCW, BITS+16, validation-error accumulator width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start a training run; sampled only in IDLE
- halt  in  1  abort the run; sampled in every non-IDLE, non-FIN state
- TRAIN, VALID, EPOCH  in  BITS each  counts from Pattern; latched on go, only low 16 bits used
- step_done  in  1  Architecture finished the current sample (one-cycle pulse)
- err  in  BITS  unsigned sample error, valid with step_done during validation
- START, END, TR, VL, SW  out  1 each  one-cycle strobes to Pattern
- step  out  1  one-cycle pulse to Architecture: x/y now stable
- epoch  out  16  current epoch index (0-based)
- sample  out  16  current sample index within the phase
- best_err  out  ACCW  lowest epoch validation error so far
- best_epoch  out  16  epoch that produced best_err
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, INIT, TR_ISSUE, TR_STEP, TR_WAIT, VL_ISSUE, VL_STEP, VL_WAIT, EVAL, STORE, FIN.
- All outputs are registered Moore decodes of state. At most one of START/TR/VL/SW/END is high in any cycle.
- **IDLE → INIT** on go. Latch the counts. Clear epoch, sample and acc. Set best_err to all-ones and best_epoch to 0.
- **INIT** pulses START. Next state:
  - FIN if EPOCH==0;
  - else TR_ISSUE if TRAIN!=0;
  - else VL_ISSUE if VALID!=0;
  - else EVAL.
- **TR_ISSUE** pulses TR, then goes to TR_STEP.
- **TR_STEP** pulses step, then goes to TR_WAIT.
- **TR_WAIT** holds until step_done, then:
  - if sample+1 < TRAIN: sample++, go to TR_ISSUE;
  - else: sample=0, go to VL_ISSUE (or EVAL if VALID==0).
- **VL_ISSUE / VL_STEP / VL_WAIT** mirror the training states.
  - On each step_done: acc += err, saturating at 2^ACCW−1.
  - After the last sample: sample=0, go to EVAL.
- **EVAL** (one cycle):
  - If VALID!=0 and acc < best_err (strict): best_err=acc, best_epoch=epoch, go to STORE.
  - Otherwise skip STORE.
- **STORE** pulses SW.
- **After EVAL/STORE:** clear acc and increment epoch. Go to FIN if the new epoch == EPOCH; otherwise go to TR_ISSUE (or VL_ISSUE/EVAL by the INIT rule).
- **FIN** pulses END, then returns to IDLE.
- **halt** forces FIN on the next edge and overrides every other transition. The best_* values are retained.
- **step_done edge cases:**
  - Outside *_WAIT it is ignored.
  - Arriving in the same cycle as step it is ignored; it must come at least 1 cycle later.
- go while busy is ignored.
- **Reset values:** state=IDLE; all strobes, step and busy = 0; epoch=sample=0; acc=0; best_err=all-ones; best_epoch=0. A reset mid-run aborts with no END.

## Timing
- go high at cycle c → START at c+1 → TR at c+2 → step at c+3.
- step_done at cycle d (d ≥ c+4) → next TR or VL at d+1.
- Pattern updates x/y on the TR/VL edge, so they are stable while step is high.
- Minimum cycles per sample: 3 (ISSUE, STEP, WAIT with step_done one cycle after step).
- Last validation step_done at d → EVAL at d+1 → SW (if any) at d+2 → next TR at d+2 or d+3.
- END is one cycle after EVAL/STORE of the final epoch, or one cycle after halt is sampled. busy drops the cycle after END.

## Structure
- Package train_pkg holds:
  - the state enum type;
  - the localparam CNTW=16;
  - the ACC_MAX constant.
- One sub-module, sat_acc: ACCW-bit saturating accumulator with clr and add_en.
- Epoch/sample counters and the FSM stay in train_sequencer.

## Test plan
- **Nominal run:** TRAIN=3, VALID=2, EPOCH=2, step_done 2 cycles after each step → exactly 1 START, 6 TR, 4 VL, 1 END. Per-epoch sample order 0,1,2 then 0,1. epoch reaches 2 at END.
- **Best-weight tracking:** err per epoch sums 10, 7, 9, 7 → SW pulses after epochs 0 and 1 only; best_err=7, best_epoch=1.
- **Zero counts:**
  - EPOCH=0 → START at c+1, END at c+2, no TR/VL/SW.
  - VALID=0 → no VL and no SW; the TR count is correct.
- **Saturation:** ACCW=BITS+16 with err=32'hFFFF_FFFF for 2^16+4 validation samples → acc holds 2^ACCW−1 and does not wrap.
- **Abort:** halt asserted in TR_WAIT of epoch 1 → END on the next cycle, no further TR, best_* unchanged. A new go restarts from epoch 0.
- **Async reset and strays:**
  - rst asserted between clock edges mid-VL phase → outputs reach reset values immediately, with no END.
  - step_done in IDLE or the same cycle as step → ignored.
